// File: rtl/block_memory_responder.sv
// Main-memory responder for cache block refills: four-phase memRead/memReady
// handshake, fixed access latency, four sequential word reads per block.
module block_memory_responder #(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORD_COUNT     = 4,
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned ACCESS_LATENCY = 3,
  parameter int unsigned REQ_W          = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            memRead,
  input  logic [ADDR_WIDTH-3:0]           blockAddress,
  output logic [WORD_SIZE*WORD_COUNT-1:0] dataOut,
  output logic                            memReady,
  output logic                            busy,
  input  logic                            write,
  input  logic [ADDR_WIDTH-1:0]           writeAddress,
  input  logic [WORD_SIZE-1:0]            writeData,
  output logic [REQ_W-1:0]                requestCount
);

  localparam int unsigned BLK_W    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned DATA_W   = WORD_SIZE * WORD_COUNT;
  localparam int unsigned LAT_W    = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam int unsigned LAT_LAST = (ACCESS_LATENCY > 0) ? ACCESS_LATENCY - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BLK_W-1:0]     addr_q, addr_d;
  logic [1:0]           beat_q, beat_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [REQ_W-1:0]     count_q, count_d;
  logic                 armed_q, armed_d;
  logic                 dropped_q, dropped_d;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] rd_idx_c;
  logic [WORD_SIZE-1:0]  rd_word_c;

  // Words are stored XORed with their own address, so a zero-filled array
  // (simulator power-up) reads back as word[a] = a without any init code.
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  assign rd_idx_c  = {addr_q, beat_q};
  assign rd_word_c = mem_q[rd_idx_c] ^ WORD_SIZE'(rd_idx_c);

  // Word store write port; not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[writeAddress] <= writeData ^ WORD_SIZE'(writeAddress);
    end
  end

  // Next-state, beat sequencing and block assembly.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    data_d    = data_q;
    count_d   = count_q;
    armed_d   = armed_q;
    dropped_d = dropped_q;
    mem_we_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_we_c = write;
        if (!memRead) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          addr_d    = blockAddress;
          count_d   = count_q + REQ_W'(1);
          beat_d    = 2'd0;
          lat_d     = '0;
          armed_d   = 1'b0;
          dropped_d = 1'b0;
          state_d   = (ACCESS_LATENCY == 0) ? S_READ : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!memRead) dropped_d = 1'b1;
        if (lat_q == LAT_W'(LAT_LAST)) begin
          state_d = S_READ;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_READ: begin
        if (!memRead) dropped_d = 1'b1;
        data_d[WORD_SIZE*32'(beat_q) +: WORD_SIZE] = rd_word_c;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        // A request dropped early gets a single-cycle memReady pulse.
        if (!memRead) armed_d = 1'b1;
        if (!memRead || dropped_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      armed_q   <= 1'b1;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
      dropped_q <= dropped_d;
    end
  end

  assign dataOut      = data_q;
  assign memReady     = ready_q;
  assign busy         = busy_q;
  assign requestCount = count_q;

endmodule
